// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and constants for the LFSR random word generator
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rng_state_e;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  localparam logic [15:0] SEED_TABLE [4] = '{16'hACE1, 16'h1D2B, 16'h7F3C, 16'hC0DE};

endpackage

// File: rtl/rng_lfsr_step.sv
// rtl/rng_lfsr_step.sv - one combinational Galois LFSR shift
module rng_lfsr_step #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = x_i[0] ? ((x_i >> 1) ^ TAPS) : (x_i >> 1);

endmodule

// File: rtl/rng_lfsr_core.sv
// rtl/rng_lfsr_core.sv - seeded, whitened LFSR draw with valid/ready output
module rng_lfsr_core
  import rng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
  parameter int               STEPS = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       seed_sel_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] rnd_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam logic [7:0] LAST_CNT = 8'(STEPS - 1);

  rng_state_e       state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0] rnd_step;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] mix;

  rng_lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_lfsr (
    .x_i (lfsr_q),
    .y_o (lfsr_step)
  );

  rng_lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step_rnd (
    .x_i (lfsr_q),
    .y_o (rnd_step)
  );

  assign seed = SEED_TABLE[seed_sel_i];
  assign mix  = lfsr_q ^ seed;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          // A zero mix would lock the LFSR; fall back to the raw seed instead.
          lfsr_d  = (mix == '0) ? seed : mix;
          cnt_d   = 8'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          rnd_d   = rnd_step;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= 8'd0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rnd_o   = rnd_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_rng_lfsr_core.sv
// tb/tb_rng_lfsr_core.sv - randomized self-checking bench for rng_lfsr_core
module tb_rng_lfsr_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, ready1, valid1, busy1;
  logic [1:0]  sel1;
  logic [15:0] rnd1;
  logic        start8, ready8, valid8, busy8;
  logic [1:0]  sel8;
  logic [15:0] rnd8;
  logic [15:0] step_x, step_y;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr1, m_lfsr8;
  logic [15:0] seeds [4] = '{16'hACE1, 16'h1D2B, 16'h7F3C, 16'hC0DE};

  rng_lfsr_core #(.WIDTH(16), .TAPS(16'hB400), .STEPS(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start1), .seed_sel_i(sel1),
    .ready_i(ready1), .rnd_o(rnd1), .valid_o(valid1), .busy_o(busy1)
  );

  rng_lfsr_core #(.WIDTH(16), .TAPS(16'hB400), .STEPS(8)) dut8 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start8), .seed_sel_i(sel8),
    .ready_i(ready8), .rnd_o(rnd8), .valid_o(valid8), .busy_o(busy8)
  );

  rng_lfsr_step #(.WIDTH(16), .TAPS(16'hB400)) u_step (.x_i(step_x), .y_o(step_y));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] x);
    int v;
    v = int'(x);
    if (v % 2 == 1) return 16'((v / 2) ^ 32'hB400);
    return 16'(v / 2);
  endfunction

  // Returns the LFSR state after a whole draw; that state is also the drawn word.
  function automatic logic [15:0] ref_draw(input logic [15:0] st, input logic [1:0] sel,
                                           input int steps);
    logic [15:0] s;
    s = st ^ seeds[sel];
    if (s == 16'h0000) s = seeds[sel];
    for (int i = 0; i < steps; i++) s = ref_step(s);
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic draw(input int which, input logic [1:0] sel, output logic [15:0] word,
                      output int lat);
    if (which == 1) begin start1 = 1'b1; sel1 = sel; end
    else            begin start8 = 1'b1; sel8 = sel; end
    tick;
    start1 = 1'b0;
    start8 = 1'b0;
    sel1   = 2'($urandom);
    sel8   = 2'($urandom);
    lat = 1;
    while (!((which == 1) ? valid1 : valid8) && lat < 300) begin
      tick;
      lat++;
    end
    word = (which == 1) ? rnd1 : rnd8;
  endtask

  task automatic accept(input int which);
    if (which == 1) ready1 = 1'b1; else ready8 = 1'b1;
    tick;
    ready1 = 1'b0;
    ready8 = 1'b0;
  endtask

  task automatic reset_release;
    #3 rst_n = 1'b1;
    m_lfsr1 = 16'h0000;
    m_lfsr8 = 16'h0000;
    tick;
  endtask

  initial begin
    logic [15:0] w, w_exp, held;
    logic [15:0] words [4];
    int lat, which, steps;
    logic [1:0] sel;

    rst_n = 1'b0;
    start1 = 0; ready1 = 0; sel1 = 0;
    start8 = 0; ready8 = 0; sel8 = 0;
    step_x = 16'h0000;
    #12;
    check("reset_valid1", {31'd0, valid1}, 32'd0);
    check("reset_busy1", {31'd0, busy1}, 32'd0);
    check("reset_rnd8", {16'd0, rnd8}, 32'd0);
    reset_release;

    // Latency and word with STEPS=1, held while ready stays low.
    draw(1, 2'd0, w, lat);
    m_lfsr1 = ref_draw(m_lfsr1, 2'd0, 1);
    check("t1_latency", lat, 32'd2);
    check("t1_rnd", {16'd0, w}, 32'h0000E270);
    check("t1_model", {16'd0, w}, {16'd0, m_lfsr1});
    check("t1_busy", {31'd0, busy1}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("t1_hold_valid", {31'd0, valid1}, 32'd1);
      check("t1_hold_rnd", {16'd0, rnd1}, 32'h0000E270);
    end
    accept(1);
    check("t1_release_valid", {31'd0, valid1}, 32'd0);
    check("t1_release_busy", {31'd0, busy1}, 32'd0);
    check("t1_release_rnd", {16'd0, rnd1}, 32'h0000E270);

    // LFSR state carries into the next draw.
    draw(1, 2'd0, w, lat);
    m_lfsr1 = ref_draw(m_lfsr1, 2'd0, 1);
    check("t2_rnd", {16'd0, w}, 32'h00009348);
    check("t2_model", {16'd0, w}, {16'd0, m_lfsr1});
    accept(1);

    // Step function alone.
    step_x = 16'hACE1; #1 check("t3_ace1", {16'd0, step_y}, 32'h0000E270);
    step_x = 16'hE270; #1 check("t3_e270", {16'd0, step_y}, 32'h00007138);
    step_x = 16'h0001; #1 check("t3_0001", {16'd0, step_y}, 32'h0000B400);
    for (int i = 0; i < 8; i++) begin
      step_x = 16'($urandom);
      #1 check("t3_rand", {16'd0, step_y}, {16'd0, ref_step(step_x)});
    end

    // STEPS=8, every seed index from a fresh reset.
    for (int s = 0; s < 4; s++) begin
      #2 rst_n = 1'b0;
      reset_release;
      draw(8, 2'(s), w, lat);
      check("t4_latency", lat, 32'd9);
      check("t4_rnd", {16'd0, w}, {16'd0, ref_draw(16'h0000, 2'(s), 8)});
      words[s] = w;
      accept(8);
    end
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        check("t4_distinct", {31'd0, words[i] != words[j]}, 32'd1);
    m_lfsr8 = ref_draw(16'h0000, 2'd3, 8);

    // Random back-to-back draws on both instances with random consumer stalls.
    for (int i = 0; i < 12; i++) begin
      which = ($urandom_range(0, 1) == 0) ? 1 : 8;
      sel   = 2'($urandom);
      steps = (which == 1) ? 1 : 8;
      draw(which, sel, w, lat);
      if (which == 1) begin m_lfsr1 = ref_draw(m_lfsr1, sel, 1); w_exp = m_lfsr1; end
      else            begin m_lfsr8 = ref_draw(m_lfsr8, sel, 8); w_exp = m_lfsr8; end
      check("rand_latency", lat, steps + 1);
      check("rand_rnd", {16'd0, w}, {16'd0, w_exp});
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        tick;
        held = (which == 1) ? rnd1 : rnd8;
        check("rand_stall_rnd", {16'd0, held}, {16'd0, w_exp});
      end
      accept(which);
    end

    // Starts and seed changes outside IDLE are ignored.
    start8 = 1'b1; sel8 = 2'd1;
    tick;
    m_lfsr8 = ref_draw(m_lfsr8, 2'd1, 8);
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      sel8 = 2'($urandom);
      tick;
      lat++;
    end
    start8 = 1'b0;
    while (!valid8 && lat < 300) begin
      sel8 = 2'($urandom);
      tick;
      lat++;
    end
    check("t5_latency", lat, 32'd9);
    check("t5_rnd", {16'd0, rnd8}, {16'd0, m_lfsr8});
    ready8 = 1'b1; start8 = 1'b1; sel8 = 2'd2;
    tick;
    ready8 = 1'b0; start8 = 1'b0;
    check("t5_valid", {31'd0, valid8}, 32'd0);
    check("t5_busy", {31'd0, busy8}, 32'd0);
    check("t5_rnd_kept", {16'd0, rnd8}, {16'd0, m_lfsr8});
    for (int i = 0; i < 5; i++) tick;
    check("t5_no_draw", {31'd0, busy8 | valid8}, 32'd0);
    draw(8, 2'd2, w, lat);
    m_lfsr8 = ref_draw(m_lfsr8, 2'd2, 8);
    check("t5_next_rnd", {16'd0, w}, {16'd0, m_lfsr8});
    accept(8);

    // Asynchronous reset in RUN (cnt=3) and in DONE.
    start8 = 1'b1; sel8 = 2'd0;
    tick;
    start8 = 1'b0;
    tick; tick; tick;
    #2 rst_n = 1'b0;
    #1;
    check("t6_run_busy", {31'd0, busy8}, 32'd0);
    check("t6_run_valid", {31'd0, valid8}, 32'd0);
    check("t6_run_rnd", {16'd0, rnd8}, 32'd0);
    reset_release;
    draw(8, 2'd3, w, lat);
    check("t6_pre_done_valid", {31'd0, valid8}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_done_valid", {31'd0, valid8}, 32'd0);
    check("t6_done_busy", {31'd0, busy8}, 32'd0);
    check("t6_done_rnd", {16'd0, rnd8}, 32'd0);
    reset_release;
    draw(1, 2'd0, w, lat);
    check("t6_after_rnd", {16'd0, w}, 32'h0000E270);
    accept(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
